// File: rtl/keypad_scan_ev.sv
// Matrix keypad scanner: drives one active-low column at a time and samples
// the active-low rows through a two-flop synchroniser. Each key is debounced
// once per scan frame, and every committed press/release is queued as an
// event in a small valid/ready FIFO.
module keypad_scan_ev #(
  parameter int ROWS     = 4,
  parameter int COLS     = 3,
  parameter int SCAN_DIV = 50000,
  parameter int DEBOUNCE = 4,
  parameter int EV_DEPTH = 4,
  parameter int KEY_W    = $clog2(ROWS * COLS)
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [ROWS-1:0]        key_row,
  output logic [COLS-1:0]        key_col,
  output logic [ROWS*COLS-1:0]   key_state,
  output logic                   ev_valid,
  input  logic                   ev_ready,
  output logic [KEY_W-1:0]       ev_code,
  output logic                   ev_press,
  output logic                   ev_drop,
  input  logic                   drop_clr
);

  localparam int NKEYS = ROWS * COLS;
  localparam int DW    = $clog2(SCAN_DIV);
  localparam int CIW   = $clog2(COLS);
  localparam int CNTW  = $clog2(DEBOUNCE + 1);
  localparam int PW    = $clog2(EV_DEPTH);

  typedef enum logic {IDLE, WALK} walkState_t;

  logic [DW-1:0]    dwell_q;
  logic [CIW-1:0]   colIdx_q;
  logic [COLS-1:0]  col_q;
  logic [ROWS-1:0]  sync1_q, sync2_q;
  logic [NKEYS-1:0] frame_q;
  logic [NKEYS-1:0] rawFrame;
  logic             sampleTick, frameEnd;

  logic [CNTW-1:0]  cnt_q [NKEYS];
  logic [CNTW-1:0]  cnt_d [NKEYS];
  logic [NKEYS-1:0] keyState_q, keyState_d;
  logic [NKEYS-1:0] change_q, change_d, newChange;

  walkState_t       walkState_q;
  logic [KEY_W-1:0] walkIdx_q;
  logic             push;
  logic [KEY_W:0]   pushData;

  logic [KEY_W:0]   mem_q [EV_DEPTH];
  logic [PW-1:0]    wrPtr_q, wrPtr_d, rdPtr_q, rdPtr_d;
  logic [PW:0]      count_q, count_d;
  logic             evValid_q, evPress_q, evDrop_q;
  logic [KEY_W-1:0] evCode_q;
  logic             pop, full, doPush, drop;
  logic [KEY_W:0]   headNext;

  assign sampleTick = (dwell_q == DW'(SCAN_DIV - 1));
  assign frameEnd   = sampleTick && (colIdx_q == CIW'(COLS - 1));

  // Frame buffer as it will look after this cycle's column sample is merged in
  always_comb begin
    rawFrame = frame_q;
    for (int c = 0; c < COLS; c++) begin
      if (colIdx_q == CIW'(c)) rawFrame[c*ROWS +: ROWS] = ~sync2_q;
    end
  end

  // Column dwell timing, column drive rotation, row synchroniser and frame capture
  always_ff @(posedge clk) begin
    if (!rstn) begin
      dwell_q  <= '0;
      colIdx_q <= '0;
      col_q    <= {{(COLS-1){1'b1}}, 1'b0};
      sync1_q  <= '1;
      sync2_q  <= '1;
      frame_q  <= '0;
    end else begin
      sync1_q <= key_row;
      sync2_q <= sync1_q;
      if (sampleTick) begin
        dwell_q <= '0;
        frame_q <= rawFrame;
        if (colIdx_q == CIW'(COLS - 1)) begin
          colIdx_q <= '0;
          col_q    <= {{(COLS-1){1'b1}}, 1'b0};
        end else begin
          colIdx_q <= colIdx_q + 1'b1;
          col_q    <= {col_q[COLS-2:0], 1'b1};
        end
      end else begin
        dwell_q <= dwell_q + 1'b1;
      end
    end
  end

  // Per-key debounce: a key toggles only after DEBOUNCE consecutive differing frames
  always_comb begin
    cnt_d      = cnt_q;
    keyState_d = keyState_q;
    newChange  = '0;
    if (frameEnd) begin
      for (int k = 0; k < NKEYS; k++) begin
        if (rawFrame[k] == keyState_q[k]) begin
          cnt_d[k] = '0;
        end else if (cnt_q[k] == CNTW'(DEBOUNCE - 1)) begin
          keyState_d[k] = ~keyState_q[k];
          cnt_d[k]      = '0;
          newChange[k]  = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + 1'b1;
        end
      end
    end
  end

  // Walker push request: one key index per clock, only for keys that changed
  always_comb begin
    push     = (walkState_q == WALK) && change_q[walkIdx_q];
    pushData = {walkIdx_q, keyState_q[walkIdx_q]};
    change_d = change_q;
    if (push) change_d[walkIdx_q] = 1'b0;
    change_d = change_d | newChange;
  end

  // Debounce state, change bitmap and walker FSM
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int k = 0; k < NKEYS; k++) cnt_q[k] <= '0;
      keyState_q  <= '0;
      change_q    <= '0;
      walkState_q <= IDLE;
      walkIdx_q   <= '0;
    end else begin
      cnt_q      <= cnt_d;
      keyState_q <= keyState_d;
      change_q   <= change_d;
      case (walkState_q)
        IDLE: begin
          if (frameEnd && (newChange != '0)) begin
            walkState_q <= WALK;
            walkIdx_q   <= '0;
          end
        end
        WALK: begin
          if (walkIdx_q == KEY_W'(NKEYS - 1)) begin
            walkState_q <= IDLE;
            walkIdx_q   <= '0;
          end else begin
            walkIdx_q <= walkIdx_q + 1'b1;
          end
        end
        default: walkState_q <= IDLE;
      endcase
    end
  end

  // FIFO control: a push into a full FIFO survives only if a pop happens that cycle
  always_comb begin
    pop     = evValid_q && ev_ready;
    full    = (count_q == (PW+1)'(EV_DEPTH));
    doPush  = push && (!full || pop);
    drop    = push && full && !pop;
    wrPtr_d = doPush ? wrPtr_q + 1'b1 : wrPtr_q;
    rdPtr_d = pop ? rdPtr_q + 1'b1 : rdPtr_q;
    case ({doPush, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (doPush && (wrPtr_q == rdPtr_d)) headNext = pushData;
    else                                headNext = mem_q[rdPtr_d];
  end

  // Event storage; contents are qualified by the pointers so no reset is needed
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushData;
  end

  // FIFO pointers, registered head outputs and sticky drop flag (set beats clear)
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wrPtr_q   <= '0;
      rdPtr_q   <= '0;
      count_q   <= '0;
      evValid_q <= 1'b0;
      evCode_q  <= '0;
      evPress_q <= 1'b0;
      evDrop_q  <= 1'b0;
    end else begin
      wrPtr_q   <= wrPtr_d;
      rdPtr_q   <= rdPtr_d;
      count_q   <= count_d;
      evValid_q <= (count_d != '0);
      if (count_d != '0) begin
        evCode_q  <= headNext[KEY_W:1];
        evPress_q <= headNext[0];
      end
      evDrop_q <= drop | (evDrop_q & ~drop_clr);
    end
  end

  assign key_col   = col_q;
  assign key_state = keyState_q;
  assign ev_valid  = evValid_q;
  assign ev_code   = evCode_q;
  assign ev_press  = evPress_q;
  assign ev_drop   = evDrop_q;

endmodule

// File: tb/tb_keypad_scan_ev.sv
// Bench for keypad_scan_ev with a small keypad model: a pressed-key mask pulls
// the matching row low while its column is driven.
module tb_keypad_scan_ev;

  localparam int ROWS = 4, COLS = 3, SCAN_DIV = 4, DEBOUNCE = 2, EV_DEPTH = 4;
  localparam int NKEYS = ROWS * COLS;
  localparam int FRAME = SCAN_DIV * COLS;

  logic              clk = 1'b0;
  logic              rstn;
  logic [ROWS-1:0]   key_row;
  logic [COLS-1:0]   key_col;
  logic [NKEYS-1:0]  key_state;
  logic              ev_valid, ev_ready, ev_press, ev_drop, drop_clr;
  logic [3:0]        ev_code;

  logic [NKEYS-1:0]  keyMask;
  int                cyc;
  int                errors = 0;
  int                checks = 0;

  typedef struct {
    logic [3:0] code;
    logic       press;
  } ev_t;
  ev_t evLog[$];

  typedef struct {
    logic [NKEYS-1:0] keys;
    logic [NKEYS-1:0] expState;
    logic             expValid;
  } vec_t;
  vec_t vecs[8];
  logic [2:0] colTab[13];

  keypad_scan_ev #(
    .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SCAN_DIV), .DEBOUNCE(DEBOUNCE), .EV_DEPTH(EV_DEPTH)
  ) dut (
    .clk(clk), .rstn(rstn), .key_row(key_row), .key_col(key_col),
    .key_state(key_state), .ev_valid(ev_valid), .ev_ready(ev_ready),
    .ev_code(ev_code), .ev_press(ev_press), .ev_drop(ev_drop), .drop_clr(drop_clr)
  );

  always #5 clk = ~clk;

  // Keypad model: a held key shorts its row to the currently driven column
  always_comb begin
    key_row = '1;
    for (int c = 0; c < COLS; c++)
      for (int r = 0; r < ROWS; r++)
        if (!key_col[c] && keyMask[c*ROWS + r]) key_row[r] = 1'b0;
  end

  // Clocks since reset release; frame ends fall on multiples of FRAME
  always @(posedge clk) cyc <= rstn ? cyc + 1 : 0;

  // Log every accepted event
  always @(posedge clk) begin
    if (rstn && ev_valid && ev_ready) evLog.push_back('{ev_code, ev_press});
  end

  // Watchdog so the bench can never hang
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(input logic [NKEYS-1:0] keys);
    keyMask = keys;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic waitFrames(input int n);
    repeat (n) begin
      @(negedge clk);
      while (cyc % FRAME != 0) @(negedge clk);
    end
  endtask

  task automatic waitValid(input string name);
    int n = 0;
    while (!ev_valid && n < 13) begin
      @(negedge clk);
      n++;
    end
    checkOutput(name, 32'(ev_valid), 32'd1);
  endtask

  task automatic popOne(input string name, input logic [3:0] code, input logic press);
    checkOutput({name, ".valid"}, 32'(ev_valid), 32'd1);
    checkOutput({name, ".code"},  32'(ev_code),  32'(code));
    checkOutput({name, ".press"}, 32'(ev_press), 32'(press));
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
  endtask

  initial begin
    colTab = '{3'b110, 3'b110, 3'b110, 3'b110, 3'b101, 3'b101, 3'b101, 3'b101,
               3'b011, 3'b011, 3'b011, 3'b011, 3'b110};
    vecs[0] = '{12'h040, 12'h000, 1'b0};
    vecs[1] = '{12'h040, 12'h040, 1'b0};
    vecs[2] = '{12'h040, 12'h040, 1'b1};
    vecs[3] = '{12'h000, 12'h040, 1'b1};
    vecs[4] = '{12'h000, 12'h000, 1'b1};
    vecs[5] = '{12'h040, 12'h000, 1'b1};
    vecs[6] = '{12'h000, 12'h000, 1'b1};
    vecs[7] = '{12'h000, 12'h000, 1'b1};

    rstn = 1'b0; ev_ready = 1'b0; drop_clr = 1'b0;
    applyStimulus('0);
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    checkOutput("rst.keyCol", 32'(key_col), 32'b110);
    checkOutput("rst.valid", 32'(ev_valid), 32'd0);
    checkOutput("rst.state", 32'(key_state), 32'd0);
    checkOutput("rst.drop", 32'(ev_drop), 32'd0);
    checkOutput("rst.code", 32'(ev_code), 32'd0);
    checkOutput("rst.press", 32'(ev_press), 32'd0);

    for (int j = 0; j < 13; j++) begin
      checkOutput($sformatf("scan.keyCol[%0d]", j), 32'(key_col), 32'(colTab[j]));
      if (j < 12) @(negedge clk);
    end

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].keys);
      waitFrames(1);
      checkOutput($sformatf("vec[%0d].state", i), 32'(key_state), 32'(vecs[i].expState));
      checkOutput($sformatf("vec[%0d].valid", i), 32'(ev_valid), 32'(vecs[i].expValid));
    end
    popOne("key6Press", 4'd6, 1'b1);
    popOne("key6Release", 4'd6, 1'b0);
    checkOutput("glitchNoEvent", 32'(ev_valid), 32'd0);

    waitFrames(1);
    applyStimulus(12'h040);
    waitFrames(2);
    checkOutput("lat.state", 32'(key_state), 32'h040);
    waitValid("lat.pressValid");
    popOne("lat.press", 4'd6, 1'b1);
    waitFrames(1);
    applyStimulus(12'h000);
    waitFrames(2);
    checkOutput("lat.relState", 32'(key_state), 32'h000);
    waitValid("lat.releaseValid");
    popOne("lat.release", 4'd6, 1'b0);
    checkOutput("lat.empty", 32'(ev_valid), 32'd0);

    waitFrames(1);
    evLog.delete();
    ev_ready = 1'b1;
    applyStimulus(12'h821);
    waitFrames(2);
    checkOutput("multi.state", 32'(key_state), 32'h821);
    repeat (14) @(negedge clk);
    ev_ready = 1'b0;
    checkOutput("multi.count", 32'(evLog.size()), 32'd3);
    if (evLog.size() == 3) begin
      checkOutput("multi.code0", 32'(evLog[0].code), 32'd0);
      checkOutput("multi.code1", 32'(evLog[1].code), 32'd5);
      checkOutput("multi.code2", 32'(evLog[2].code), 32'd11);
      checkOutput("multi.press", 32'({evLog[0].press, evLog[1].press, evLog[2].press}), 32'b111);
    end

    waitFrames(1);
    applyStimulus(12'h87F);
    waitFrames(2);
    checkOutput("full.state", 32'(key_state), 32'h87F);
    checkOutput("full.dropBefore", 32'(ev_drop), 32'd0);
    repeat (6) @(negedge clk);
    drop_clr = 1'b1;
    @(negedge clk);
    drop_clr = 1'b0;
    checkOutput("full.dropSetWins", 32'(ev_drop), 32'd1);
    checkOutput("full.valid", 32'(ev_valid), 32'd1);
    checkOutput("full.headCode", 32'(ev_code), 32'd1);
    checkOutput("full.headPress", 32'(ev_press), 32'd1);
    drop_clr = 1'b1;
    @(negedge clk);
    drop_clr = 1'b0;
    checkOutput("full.dropClr", 32'(ev_drop), 32'd0);

    waitFrames(1);
    applyStimulus(12'h8FF);
    waitFrames(2);
    checkOutput("pushPop.state", 32'(key_state), 32'h8FF);
    repeat (7) @(negedge clk);
    ev_ready = 1'b1;
    @(negedge clk);
    ev_ready = 1'b0;
    checkOutput("pushPop.drop", 32'(ev_drop), 32'd0);
    popOne("pushPop.e2", 4'd2, 1'b1);
    popOne("pushPop.e3", 4'd3, 1'b1);
    popOne("pushPop.e4", 4'd4, 1'b1);
    popOne("pushPop.e7", 4'd7, 1'b1);
    checkOutput("pushPop.empty", 32'(ev_valid), 32'd0);

    waitFrames(1);
    applyStimulus(12'h000);
    waitFrames(2);
    checkOutput("walkRst.stateBefore", 32'(key_state), 32'h000);
    repeat (2) @(negedge clk);
    checkOutput("walkRst.queued", 32'(ev_valid), 32'd1);
    checkOutput("walkRst.headCode", 32'(ev_code), 32'd0);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("walkRst.valid", 32'(ev_valid), 32'd0);
    checkOutput("walkRst.state", 32'(key_state), 32'd0);
    checkOutput("walkRst.keyCol", 32'(key_col), 32'b110);
    repeat (4) @(negedge clk);
    checkOutput("walkRst.keyCol1", 32'(key_col), 32'b101);
    repeat (8) @(negedge clk);
    checkOutput("walkRst.noStaleEvents", 32'(ev_valid), 32'd0);
    applyStimulus(12'h008);
    waitFrames(2);
    checkOutput("walkRst.newState", 32'(key_state), 32'h008);
    waitValid("walkRst.newValid");
    popOne("walkRst.newEvent", 4'd3, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
